// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, multi-cycle
// mult/div occupancy of EX, and data-SRAM wait, plus a stall-cycle counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no mult/div in flight; EX may accept a new mult/div start
// BUSY  | mult/div occupying EX; counter counts remaining cycles down
module pipe_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_re,
    input  logic        id_rt_re,
    input  logic        ex_load,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_muldiv_start,
    input  logic [1:0]  ex_muldiv_op,
    input  logic        mem_wait,
    output logic [5:0]  stall,
    output logic        muldiv_busy,
    output logic        muldiv_finish,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [5:0] STALL_MEM    = 6'b011111;
    localparam logic [5:0] STALL_MULDIV = 6'b001111;
    localparam logic [5:0] STALL_LOAD   = 6'b000111;
    localparam logic [5:0] STALL_NONE   = 6'b000000;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      stall_cnt_q;

    logic             op_mul;
    logic             op_div;
    logic             start_ok;
    logic [CNT_W-1:0] load_val;
    logic             muldiv_stall;
    logic             finish_c;
    logic             load_use;
    logic             rs_hit;
    logic             rt_hit;
    logic [5:0]       stall_c;

    assign op_mul   = (ex_muldiv_op == 2'b01);
    assign op_div   = (ex_muldiv_op == 2'b10);
    assign start_ok = ex_muldiv_start & (op_mul | op_div);
    assign load_val = op_mul ? MUL_LOAD : DIV_LOAD;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        finish_c     = 1'b0;
        muldiv_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cnt_d = load_val;
                    // a single-cycle op completes in its start cycle without stalling
                    if (load_val == CNT_ZERO) begin
                        finish_c = 1'b1;
                    end else begin
                        state_d      = BUSY;
                        muldiv_stall = 1'b1;
                    end
                end
            end
            BUSY: begin
                muldiv_stall = (cnt_q != CNT_ZERO) | mem_wait;
                if (mem_wait) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    finish_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rs_hit   = id_rs_re & (id_rs == ex_waddr);
    assign rt_hit   = id_rt_re & (id_rt == ex_waddr);
    assign load_use = id_valid & ex_load & (ex_waddr != 5'd0) & (rs_hit | rt_hit);

    always_comb begin
        stall_c = STALL_NONE;
        if (mem_wait) begin
            stall_c = STALL_MEM;
        end else if (muldiv_stall) begin
            stall_c = STALL_MULDIV;
        end else if (load_use) begin
            stall_c = STALL_LOAD;
        end
    end

    // outputs are forced quiet while reset is held, even if inputs still request work
    assign stall         = rst ? stall_c : STALL_NONE;
    assign muldiv_busy   = rst & (state_q == BUSY);
    assign muldiv_finish = rst & finish_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall[0]) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: per-cycle expectations are queued
// as stimulus is driven and compared when the outputs settle.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_re;
    logic        id_rt_re;
    logic        ex_load;
    logic [4:0]  ex_waddr;
    logic        ex_muldiv_start;
    logic [1:0]  ex_muldiv_op;
    logic        mem_wait;
    logic [5:0]  stall;
    logic        muldiv_busy;
    logic        muldiv_finish;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [5:0] stall;
        logic       busy;
        logic       fin;
        string      name;
        int         cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks;
    int          failures;
    logic [31:0] exp_cnt;

    pipe_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .ex_load(ex_load), .ex_waddr(ex_waddr),
        .ex_muldiv_start(ex_muldiv_start), .ex_muldiv_op(ex_muldiv_op),
        .mem_wait(mem_wait),
        .stall(stall), .muldiv_busy(muldiv_busy),
        .muldiv_finish(muldiv_finish), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic v, input logic [4:0] rs, input logic rsre,
                          input logic [4:0] rt, input logic rtre, input logic ld,
                          input logic [4:0] wa, input logic st, input logic [1:0] op,
                          input logic mw);
        id_valid = v; id_rs = rs; id_rs_re = rsre; id_rt = rt; id_rt_re = rtre;
        ex_load = ld; ex_waddr = wa; ex_muldiv_start = st; ex_muldiv_op = op;
        mem_wait = mw;
    endtask

    task automatic push_exp(input logic [5:0] s, input logic b, input logic f,
                            input string n, input int c);
        exp_t x;
        x.stall = s; x.busy = b; x.fin = f; x.name = n; x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        #12;
        checks++;
        if (stall !== 6'b0 || muldiv_busy !== 1'b0 || muldiv_finish !== 1'b0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: stall=%b busy=%b fin=%b cnt=%0d required 000000/0/0/0",
                     stall, muldiv_busy, muldiv_finish, stall_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_cnt = 32'd0;
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin set_in(1, 8, 1, 3, 0, 1, 8, 0, 2'b00, 0); push_exp(6'b000111, 0, 0, "lu_rs", k); end
                1: begin set_in(1, 0, 1, 0, 0, 1, 0, 0, 2'b00, 0); push_exp(6'b000000, 0, 0, "lu_r0", k); end
                2: begin set_in(1, 4, 1, 9, 1, 1, 9, 0, 2'b00, 0); push_exp(6'b000111, 0, 0, "lu_rt", k); end
                3: begin set_in(1, 4, 1, 9, 0, 1, 9, 0, 2'b00, 0); push_exp(6'b000000, 0, 0, "lu_rt_nore", k); end
                4: begin set_in(0, 8, 1, 3, 0, 1, 8, 0, 2'b00, 0); push_exp(6'b000000, 0, 0, "lu_novalid", k); end
                default: begin set_in(1, 8, 1, 3, 0, 0, 8, 0, 2'b00, 0); push_exp(6'b000000, 0, 0, "lu_noload", k); end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL lu_stall_cnt: got %0d required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_mult();
        logic [31:0] base;
        base = stall_cnt;
        for (int k = 0; k <= 5; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, (k <= 4), 2'b01, 0);
            push_exp((k <= 3) ? 6'b001111 : 6'b000000, (k >= 1 && k <= 4), (k == 4), "mult", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== base + 32'd4 || stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL mult_stall_cnt: got %0d required %0d", stall_cnt, base + 32'd4);
        end
    endtask

    task automatic test_ignored_op();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, (k == 0) ? 2'b11 : 2'b00, 0);
            push_exp(6'b000000, 0, 0, (k == 0) ? "op11" : "op00", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_mem_wait();
        logic mw;
        for (int k = 0; k <= 37; k++) begin
            mw = (k >= 10 && k <= 12);
            set_in(0, 0, 0, 0, 0, 0, 0, (k <= 36), 2'b10, mw);
            push_exp(mw ? 6'b011111 : ((k <= 35) ? 6'b001111 : 6'b000000),
                     (k >= 1 && k <= 36), (k == 36), "div_mw", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL div_stall_cnt: got %0d required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_priority();
        logic [31:0] base;
        logic [5:0]  s;
        base = stall_cnt;
        for (int k = 0; k <= 6; k++) begin
            if (k <= 5) set_in(1, 7, 1, 0, 0, 1, 7, 1, 2'b01, (k == 2));
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
            s = (k == 2) ? 6'b011111 : (k <= 4) ? 6'b001111 : (k == 5) ? 6'b000111 : 6'b000000;
            push_exp(s, (k >= 1 && k <= 5), (k == 5), "prio", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cnt !== base + 32'd6 || stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL prio_stall_cnt: got %0d required %0d", stall_cnt, base + 32'd6);
        end
    endtask

    task automatic test_reset_mid_busy();
        for (int k = 0; k <= 13; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
            push_exp(6'b001111, (k >= 1), 0, "rst_pre", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            if (k < 13) begin
                @(posedge clk); #1;
            end
        end
        // now in cycle 13 (counter at 20), past the falling edge; assert reset before the next rising edge
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 6'b0 || muldiv_busy !== 1'b0 || muldiv_finish !== 1'b0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_async: stall=%b busy=%b fin=%b cnt=%0d required 000000/0/0/0",
                     stall, muldiv_busy, muldiv_finish, stall_cnt);
        end
        exp_cnt = 32'd0;
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        rst = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, (k >= 1 && k <= 5), 2'b01, 0);
            push_exp((k >= 1 && k <= 4) ? 6'b001111 : 6'b000000, (k >= 2 && k <= 5), (k == 5), "rst_post", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            if (k == 0) begin
                checks++;
                if (stall_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL rst_post_cnt: got %0d required 0", stall_cnt);
                end
            end
            @(posedge clk); #1;
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL rst_post_total: got %0d required %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
            else        set_in(1, 5, 1, 0, 0, 1, 5, 0, 2'b00, 0);
            push_exp((k == 1) ? 6'b000000 : 6'b000111, 0, 0, "wrap", k);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || muldiv_busy !== e.busy || muldiv_finish !== e.fin) begin
                failures++;
                $display("FAIL %s cyc%0d: stall=%b busy=%b fin=%b required stall=%b busy=%b fin=%b",
                         e.name, e.cyc, stall, muldiv_busy, muldiv_finish, e.stall, e.busy, e.fin);
            end
            if (e.stall[0]) exp_cnt++;
            @(posedge clk); #1;
            checks++;
            if (stall_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL wrap_cnt cyc%0d: got %h required %h", k, stall_cnt, exp_cnt);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 32'd0;
        test_reset();
        test_load_use();
        test_mult();
        test_ignored_op();
        test_div_mem_wait();
        test_priority();
        test_reset_mid_busy();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central hazard and stall controller for the 5-stage MIPS pipeline. It generates the 6-bit stall bus consumed by the PC, IF, ID, EX, MEM and WB pipeline registers from three hazard sources:
- load-use hazards detected against ID operands;
- multi-cycle mult/div occupancy of EX, sequenced by an internal FSM and counter;
- data-SRAM wait in MEM.

It also keeps a free-running stall-cycle performance counter.

Parameters:
MUL_CYCLES, 4, EX occupancy in cycles for mult/multu (>=1).
DIV_CYCLES, 33, EX occupancy in cycles for div/divu (>=1).
CNT_W, 6, counter width; MUL_CYCLES and DIV_CYCLES must each be < 2^CNT_W.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
id_valid  in  1  ID holds a valid instruction.
id_rs  in  5  ID rs field.
id_rt  in  5  ID rt field.
id_rs_re  in  1  ID instruction reads rs.
id_rt_re  in  1  ID instruction reads rt.
ex_load  in  1  EX instruction is a load (lb/lbu/lh/lhu/lw).
ex_waddr  in  5  EX destination register.
ex_muldiv_start  in  1  EX holds a mult/div instruction.
ex_muldiv_op  in  2  00 none, 01 mult/multu, 10 div/divu, 11 treated as none.
mem_wait  in  1  data SRAM not ready; MEM must hold.
stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
muldiv_busy  out  1  FSM is in BUSY.
muldiv_finish  out  1  one-cycle pulse: mult/div result valid, EX may advance.
stall_cnt  out  32  count of cycles with stall[0]=1.

Behaviour:
Reset (rst=0, asynchronous) clears all state regardless of FSM state, including mid-BUSY:
- FSM to IDLE, counter to 0, stall_cnt to 0.
- stall=0, muldiv_busy=0, muldiv_finish=0.

FSM states:
- IDLE:
  - ex_muldiv_start=1 with op 01 loads the counter with MUL_CYCLES-1; with op 10 it loads DIV_CYCLES-1.
  - Goes to BUSY, or straight back to IDLE with finish if the loaded value is 0 (N=1 case: finish pulses in the start cycle and no stall is raised).
  - start is ignored when op is 00 or 11.
- BUSY:
  - If mem_wait=1: counter holds, no transition.
  - Else if counter>0: decrement.
  - Else (counter==0): muldiv_finish=1 for that cycle only, go to IDLE.
  - ex_muldiv_start is ignored in BUSY, so the still-present instruction does not restart the sequence in its finish cycle.

muldiv_stall is combinational:
- asserted in IDLE when a start is accepted and N>1;
- asserted in BUSY while counter>0 or mem_wait=1.
- Net effect: an N-cycle op with no mem_wait stalls exactly cycles 0..N-1 (start = cycle 0) and pulses finish in cycle N.

load_use (combinational) = id_valid & ex_load & (ex_waddr!=0) & ((id_rs_re & id_rs==ex_waddr) | (id_rt_re & id_rt==ex_waddr)).

stall, combinational from current state and inputs, highest priority first:
- mem_wait=1: 6'b011111 (WB receives bubble).
- muldiv_stall: 6'b001111 (MEM receives bubble).
- load_use: 6'b000111 (EX receives bubble; exactly one bubble, because the load leaves EX next cycle).
- Otherwise: 6'b000000.

Other rules:
- Lower-priority sources are masked, not queued; they re-evaluate each cycle.
- muldiv_busy = (state==BUSY).
- stall_cnt increments by 1 on each rising edge where stall[0]=1; wraps from 0xFFFFFFFF to 0.
- Registers written by the block: FSM state, counter, stall_cnt. Everything else is combinational.

Test Plan:
- Reset: drive rst=0 mid-BUSY with the counter at 20 -> outputs go to 0 immediately without a clock edge; after release the FSM is IDLE and stall_cnt=0.
- Load-use: ex_load=1, ex_waddr=8, id_valid=1, id_rs_re=1, id_rs=8 for one cycle -> stall=000111 that cycle; repeat with ex_waddr=0 -> stall=000000.
- Mult, MUL_CYCLES=4: ex_muldiv_start=1, op=01 held -> stall=001111 on cycles 0..3, muldiv_busy on cycles 1..4, finish pulse on cycle 4 with stall=0 and no restart; stall_cnt=4.
- Div with mem_wait: op=10, mem_wait=1 during cycles 10..12 -> stall=011111 on those cycles, counter frozen, finish in cycle 36 instead of 33.
- Priority: load_use and BUSY both active -> stall=001111; then add mem_wait -> 011111; stall_cnt increments on every such cycle.
- Wrap: force stall_cnt to 0xFFFFFFFF, assert one stall cycle -> stall_cnt=0.
